regfile_sb: RTL and testbench

- Parametrised general-purpose register file with N combinational read ports, one write port, optional same-cycle write-to-read bypass, and a per-register busy scoreboard.
- Successor to the fixed 2-read/32x32 register file.
- Sits between decode (read/reserve) and writeback (write/release) of the rv32i core; decode uses the busy flags to detect RAW hazards and stall.

---
 rtl/regfile_sb.sv | 91 +++++++++
 tb/tb_regfile_sb.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Parametrised register file with N combinational read ports, one write port,
// optional write-to-read bypass and a per-register busy scoreboard for RAW stalls.
module regfile_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned ADDR_W = $clog2(NREGS),
  parameter int unsigned NREAD  = 2,
  parameter bit          BYPASS = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREAD*ADDR_W-1:0] rd_addr,
  output logic [NREAD*XLEN-1:0]   rd_data,
  output logic [NREAD-1:0]        rd_busy,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [XLEN-1:0]         wr_data,
  input  logic                    rsv_en,
  input  logic [ADDR_W-1:0]       rsv_addr,
  output logic [ADDR_W:0]         busy_cnt
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  // Index 0 is hardwired zero; indices past NREGS do not exist.
  function automatic logic idx_ok(input logic [ADDR_W-1:0] a);
    return (a != '0) && (CNT_W'(a) < CNT_W'(NREGS));
  endfunction

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [CNT_W-1:0] r_busy_cnt;

  logic w_wr_ok;
  logic w_rsv_ok;
  logic w_cnt_inc;
  logic w_cnt_dec;

  assign w_wr_ok  = wr_en  && idx_ok(wr_addr);
  assign w_rsv_ok = rsv_en && idx_ok(rsv_addr);

  // A same-index reserve overrides the release, so that case never decrements.
  assign w_cnt_inc = w_rsv_ok && !r_busy[rsv_addr];
  assign w_cnt_dec = w_wr_ok && r_busy[wr_addr] && !(w_rsv_ok && (rsv_addr == wr_addr));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      if (w_wr_ok) begin
        r_regs[wr_addr] <= wr_data;
        r_busy[wr_addr] <= 1'b0;
      end
      if (w_rsv_ok) begin
        r_busy[rsv_addr] <= 1'b1;
      end
      if (w_cnt_inc && !w_cnt_dec) begin
        r_busy_cnt <= r_busy_cnt + CNT_W'(1);
      end else if (w_cnt_dec && !w_cnt_inc) begin
        r_busy_cnt <= r_busy_cnt - CNT_W'(1);
      end
    end
  end

  assign busy_cnt = r_busy_cnt;

  // Read ports, with optional forwarding of the in-flight writeback.
  always_comb begin
    logic [ADDR_W-1:0] w_ra;
    w_ra    = '0;
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned p = 0; p < NREAD; p++) begin
      w_ra = rd_addr[p*ADDR_W +: ADDR_W];
      if (idx_ok(w_ra)) begin
        if (BYPASS && w_wr_ok && (wr_addr == w_ra)) begin
          rd_data[p*XLEN +: XLEN] = wr_data;
          rd_busy[p]              = 1'b0;
        end else begin
          rd_data[p*XLEN +: XLEN] = r_regs[w_ra];
          rd_busy[p]              = r_busy[w_ra];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a 32x32/2-port bypassing instance and a 24-entry/4-port
// non-bypassing instance share one stimulus stream, checked against an array model.
module tb_regfile_sb;

  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [4*AW-1:0] rd_addr;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [31:0]     wr_data;
  logic            rsv_en;
  logic [AW-1:0]   rsv_addr;

  logic [63:0]  rd_data_a;
  logic [1:0]   rd_busy_a;
  logic [AW:0]  busy_cnt_a;
  logic [127:0] rd_data_b;
  logic [3:0]   rd_busy_b;
  logic [AW:0]  busy_cnt_b;

  regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1'b1)) dut_a (
    .clk(clk), .reset(reset), .rd_addr(rd_addr[2*AW-1:0]), .rd_data(rd_data_a),
    .rd_busy(rd_busy_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_cnt(busy_cnt_a)
  );

  regfile_sb #(.XLEN(32), .NREGS(24), .NREAD(4), .BYPASS(1'b0)) dut_b (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_cnt(busy_cnt_b)
  );

  typedef struct {
    int           phase;
    logic [63:0]  da;
    logic [1:0]   ba;
    logic [5:0]   ca;
    logic [127:0] db;
    logic [3:0]   bb;
    logic [5:0]   cb;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: instance 0 = 32 regs with bypass, instance 1 = 24 regs without.
  logic [31:0] mem   [2][32];
  bit          bsy   [2][32];
  int          nregs [2] = '{32, 24};
  bit          byp   [2] = '{1'b1, 1'b0};

  bit          p_rst, p_we, p_re;
  int          p_wa, p_ra;
  logic [31:0] p_wd;
  int          p_rd [4];

  function automatic bit ok(int k, int a);
    return (a != 0) && (a < nregs[k]);
  endfunction

  function automatic int popc(int k);
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(bsy[k][i]);
    return n;
  endfunction

  task automatic commit();
    for (int k = 0; k < 2; k++) begin
      if (p_rst) begin
        for (int i = 0; i < 32; i++) begin
          mem[k][i] = '0;
          bsy[k][i] = 1'b0;
        end
      end else begin
        if (p_we && ok(k, p_wa)) begin
          mem[k][p_wa] = p_wd;
          bsy[k][p_wa] = 1'b0;
        end
        if (p_re && ok(k, p_ra)) bsy[k][p_ra] = 1'b1;
      end
    end
  endtask

  task automatic exp_rd(input int k, input int a, output logic [31:0] d, output bit b);
    d = '0;
    b = 1'b0;
    if (ok(k, a)) begin
      if (byp[k] && p_we && (p_wa == a)) d = p_wd;
      else begin
        d = mem[k][a];
        b = bsy[k][a];
      end
    end
  endtask

  // One cycle: retire last cycle's ops into the model, drive new ops, queue expectations.
  task automatic step(input int ph, input bit rst, input bit we, input int wa,
                      input logic [31:0] wd, input bit re, input int ra,
                      input int r0, input int r1, input int r2, input int r3);
    exp_t        e;
    logic [31:0] d;
    bit          b;
    @(posedge clk);
    #1;
    commit();
    p_rst = rst; p_we = we; p_wa = wa; p_wd = wd; p_re = re; p_ra = ra;
    p_rd[0] = r0; p_rd[1] = r1; p_rd[2] = r2; p_rd[3] = r3;
    reset    = rst;
    wr_en    = we;
    wr_addr  = AW'(wa);
    wr_data  = wd;
    rsv_en   = re;
    rsv_addr = AW'(ra);
    for (int p = 0; p < 4; p++) rd_addr[p*AW +: AW] = AW'(p_rd[p]);
    e.phase = ph;
    e.da = '0; e.ba = '0; e.db = '0; e.bb = '0;
    for (int p = 0; p < 2; p++) begin
      exp_rd(0, p_rd[p], d, b);
      e.da[p*32 +: 32] = d;
      e.ba[p] = b;
    end
    for (int p = 0; p < 4; p++) begin
      exp_rd(1, p_rd[p], d, b);
      e.db[p*32 +: 32] = d;
      e.bb[p] = b;
    end
    e.ca = 6'(popc(0));
    e.cb = 6'(popc(1));
    q.push_back(e);
  endtask

  task automatic idle(input int ph, input int r0, input int r1, input int r2, input int r3);
    step(ph, 1'b0, 1'b0, 0, 32'h0, 1'b0, 0, r0, r1, r2, r3);
  endtask

  task automatic chk(input string nm, input int ph, input int p, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s phase=%0d port=%0d got=%h expected=%h", nm, ph, p, act, exp);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        for (int p = 0; p < 2; p++) begin
          chk("a_rd_data", e.phase, p, rd_data_a[p*32 +: 32], e.da[p*32 +: 32]);
          chk("a_rd_busy", e.phase, p, 32'(rd_busy_a[p]), 32'(e.ba[p]));
        end
        chk("a_busy_cnt", e.phase, 0, 32'(busy_cnt_a), 32'(e.ca));
        for (int p = 0; p < 4; p++) begin
          chk("b_rd_data", e.phase, p, rd_data_b[p*32 +: 32], e.db[p*32 +: 32]);
          chk("b_rd_busy", e.phase, p, 32'(rd_busy_b[p]), 32'(e.bb[p]));
        end
        chk("b_busy_cnt", e.phase, 0, 32'(busy_cnt_b), 32'(e.cb));
      end
    end
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; rd_addr = '0;
    p_rst = 1'b1; p_we = 1'b0; p_re = 1'b0; p_wa = 0; p_ra = 0; p_wd = '0;
    repeat (3) @(posedge clk);

    // Post-reset sweep of every index on every port
    for (int a = 0; a < 32; a++) idle(1, a, a, a, 31 - a);

    // Plain write, then visible next cycle
    step(2, 1'b0, 1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 5, 5, 5, 5);
    idle(2, 5, 5, 5, 5);

    // Writes to x0 are dropped
    step(3, 1'b0, 1'b1, 0, 32'h00001234, 1'b0, 0, 0, 0, 5, 0);
    idle(3, 0, 0, 0, 0);

    // Same-cycle read of x7 during its write: bypass vs no bypass
    step(4, 1'b0, 1'b1, 7, 32'h11111111, 1'b0, 0, 0, 0, 0, 0);
    step(4, 1'b0, 1'b1, 7, 32'hA5A5A5A5, 1'b0, 0, 0, 7, 7, 7);
    idle(4, 7, 7, 7, 7);

    // Scoreboard: reserve, release, and release+reserve in one cycle
    step(5, 1'b0, 1'b0, 0, 32'h0, 1'b1, 3, 3, 4, 3, 4);
    step(5, 1'b0, 1'b0, 0, 32'h0, 1'b1, 4, 3, 4, 3, 4);
    idle(5, 3, 4, 3, 4);
    step(5, 1'b0, 1'b1, 3, 32'h33333333, 1'b0, 0, 3, 4, 3, 4);
    step(5, 1'b0, 1'b1, 4, 32'h44444444, 1'b1, 4, 4, 4, 4, 4);
    idle(5, 4, 3, 4, 3);
    step(5, 1'b0, 1'b0, 0, 32'h0, 1'b1, 4, 4, 3, 4, 3);
    idle(5, 4, 4, 4, 4);

    // Indices past NREGS on the 24-entry instance are inert
    step(6, 1'b0, 1'b1, 30, 32'hCAFEF00D, 1'b1, 30, 30, 30, 30, 30);
    step(6, 1'b0, 1'b0, 0, 32'h0, 1'b1, 25, 30, 25, 30, 25);
    idle(6, 30, 25, 30, 25);

    // Reserve x1..x31 with a reset landing mid-sequence while rsv_en is high
    for (int i = 1; i < 32; i++) step(7, (i == 16), 1'b0, 0, 32'h0, 1'b1, i, i, i - 1, 1, 16);
    idle(7, 1, 16, 20, 5);
    for (int i = 1; i < 32; i++) step(7, (i == 20), 1'b1, i, 32'(i * 7), 1'b1, 32 - i, i, 5, 7, 4);
    step(7, 1'b1, 1'b1, 9, 32'h99, 1'b1, 9, 9, 5, 7, 4);
    idle(7, 9, 5, 7, 4);

    // Random mixed traffic
    for (int n = 0; n < 2000; n++) begin
      step(8, ($urandom_range(63, 0) == 0), 1'($urandom), int'($urandom_range(31, 0)), $urandom,
           1'($urandom), int'($urandom_range(31, 0)),
           int'($urandom_range(31, 0)), int'($urandom_range(31, 0)),
           int'($urandom_range(31, 0)), int'($urandom_range(31, 0)));
    end
    idle(9, 1, 2, 3, 4);

    repeat (2) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain left=%0d expected=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
